// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - two-requester valid/ready arbiter in front of one shared combinational ULA
//
// Purpose:
//   Requester 0 (main datapath) and requester 1 (address/branch unit) share one ULA.
//   One operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
//   The operation is accepted in IDLE and drives the ULA for one cycle (EXEC).
//   The registered result/zero flag are then returned to the owning requester (RESP).
//
// Configuration:
//   ULA_ARB_FIXED_PRIO_EN - when defined, requester 0 wins every tie (requester 1 can starve).
//                           Default (undefined): ties are resolved round-robin.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid[1:0]/req_ready   per-requester operation handshake (req_ready combinational)
//   reqN_in1/in2/op/shamt      operands of requester N, sampled only at the accept edge
//   alu_in1/in2/op/shamt       to the shared ULA, always the latched operation
//   alu_result/alu_zero        from the shared ULA
//   rsp_valid[1:0]/rsp_ready   per-requester response handshake (one-hot or zero)
//   rsp_result/rsp_zero        registered ULA result and zero flag
module ula_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 4,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req0_in1,
    input  logic [W-1:0]   req0_in2,
    input  logic [OPW-1:0] req0_op,
    input  logic [SHW-1:0] req0_shamt,
    input  logic [W-1:0]   req1_in1,
    input  logic [W-1:0]   req1_in2,
    input  logic [OPW-1:0] req1_op,
    input  logic [SHW-1:0] req1_shamt,
    output logic [W-1:0]   alu_in1,
    output logic [W-1:0]   alu_in2,
    output logic [OPW-1:0] alu_op,
    output logic [SHW-1:0] alu_shamt,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_zero,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state;
    logic           last_grant;
    logic           id;
    logic [W-1:0]   in1_q;
    logic [W-1:0]   in2_q;
    logic [OPW-1:0] op_q;
    logic [SHW-1:0] shamt_q;

    logic           both;
    logic           winner;

    // A lone requester always wins; only a tie consults the priority policy.
    always_comb begin
        both = req_valid[0] & req_valid[1];
`ifdef ULA_ARB_FIXED_PRIO_EN
        winner = both ? 1'b0 : req_valid[1];
`else
        winner = both ? ~last_grant : req_valid[1];
`endif
        req_ready = 2'b00;
        if (state == S_IDLE && (|req_valid)) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
    end

    // The ULA sees the latched operation at all times, so its inputs only move at accept.
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_op    = op_q;
    assign alu_shamt = shamt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            in1_q      <= '0;
            in2_q      <= '0;
            op_q       <= '0;
            shamt_q    <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_valid  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        id         <= winner;
                        last_grant <= winner;
                        in1_q      <= winner ? req1_in1   : req0_in1;
                        in2_q      <= winner ? req1_in2   : req0_in2;
                        op_q       <= winner ? req1_op    : req0_op;
                        shamt_q    <= winner ? req1_shamt : req0_shamt;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= id ? 2'b10 : 2'b01;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    // Only the owner's rsp_ready matters; going back through IDLE
                    // means no new accept in the cycle the response is consumed.
                    if (rsp_ready[id]) begin
                        rsp_valid <= 2'b00;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
